key_scan: RTL and testbench
===========================

Name: key_scan

Overview:
Front-end key stage for the LED panel. It synchronises and debounces three raw LED keys and one raw mode key, and emits one-cycle press pulses. It also groups mode-key presses into click bursts and reports the press tally on count. Its outputs feed the LED controller's key_led, key_mode and count inputs, and it consumes that controller's clr to release a reported count.

Parameters:
DEB_CYCLES, 1000000, consecutive stable samples required to accept a level change (20 ms @ 50 MHz); must be >= 2
WIN_CYCLES, 25000000, idle window after the last mode press that closes a burst (500 ms @ 50 MHz); must be >= 2
KEY_ACTIVE, 0, pressed level of the raw keys (0 = active-low buttons)

Ports:
clk  input  1  system clock; all logic on rising edge
rst  input  1  asynchronous active-low reset
key_in  input  3  raw LED keys, asynchronous, bouncing
mode_in  input  1  raw mode key, asynchronous, bouncing
clr  input  1  clears a reported count (level, sampled each clock)
key_led  output  3  one-cycle pulse per debounced press of key_in[i]
key_mode  output  1  one-cycle pulse per debounced press of mode_in
count  output  3  mode presses in the last completed burst; 0 when none is pending

Behaviour:
- Reset (rst=0, async): all outputs 0.
  - Sync flops and debounced states go to the released level (~KEY_ACTIVE).
  - Debounce counters, window timer and tally go to 0; FSM goes to IDLE.
- Sync: two flops per key (4 keys), each reset to the released level.
- Debounce, per key, independent:
  - Counter increments on every edge where the synced level differs from the stable level.
  - When the counter = DEB_CYCLES-1 and the level still differs, the stable level takes the new value and the counter goes to 0.
  - Any edge with level == stable zeroes the counter, so a bounce restarts qualification.
- Pulses:
  - key_led[i] / key_mode goes high for exactly 1 cycle after the stable level changes from released to pressed.
  - A release generates no pulse.
  - Latency from the raw edge to the pulse is DEB_CYCLES+2 clocks.
  - A key held through reset deassertion yields one pulse DEB_CYCLES+2 clocks after reset is released.
- Click FSM (states IDLE, GATHER, HOLD), driven by the internal mode-press pulse:
  - IDLE: on a press -> GATHER; tally=1; timer=0.
  - GATHER: timer increments each cycle.
    - Press: tally=min(tally+1,7), saturating at 7; timer=0.
    - Timer = WIN_CYCLES-1 with no press that cycle: count<=tally -> HOLD.
    - Press in the same cycle as expiry: the press wins; timer restarts and the burst continues.
  - HOLD: count holds its value.
    - clr=1: count<=0; tally=0 -> IDLE.
    - Mode presses are dropped, including one in the same cycle as clr.
  - clr is ignored in IDLE and GATHER; an open burst is never aborted by clr.
- key_mode pulses fire in every FSM state, independent of the tally.
- count is registered: it changes only on the expiry edge and the clr edge.
- LED key pulses are independent of each other and of the FSM; simultaneous presses give simultaneous pulses.

Test Plan:
(Bench parameters: DEB_CYCLES=4, WIN_CYCLES=16, KEY_ACTIVE=0.)
1. key_in[1] driven low cleanly -> key_led=3'b010 for exactly 1 cycle, 6 clocks after the edge; release -> no pulse.
2. key_in[0] toggled every 2 clocks for 20 clocks, then held low -> no pulse during the bounce; one pulse 6 clocks after the final edge.
3. Mode pressed twice, 10 clocks between debounced pulses -> count=0 during GATHER; count=2 exactly 16 clocks after the second pulse; held at 2 until clr=1, then count=0 next clock.
4. 9 mode presses inside the window -> count=7 (saturated); 9 key_mode pulses seen.
5. A press arriving in the exact expiry cycle -> burst continues; the final count includes it. A press in HOLD with clr=0 -> count unchanged, key_mode still pulses.
6. rst asserted in GATHER with tally=3 -> outputs 0 immediately; after release, a new single press gives count=1.

Source files
------------

// File: rtl/key_scan.sv
// Key front end: synchronises and debounces three LED keys plus the mode key, emits
// one-cycle press pulses, and groups mode presses into click bursts reported on count.
module key_scan #(
    parameter int unsigned DEB_CYCLES = 1000000,
    parameter int unsigned WIN_CYCLES = 25000000,
    parameter bit          KEY_ACTIVE = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] key_in,
    input  logic       mode_in,
    input  logic       clr,
    output logic [2:0] key_led,
    output logic       key_mode,
    output logic [2:0] count
);

    localparam int unsigned   NK      = 4;
    localparam int unsigned   DW      = $clog2(DEB_CYCLES);
    localparam int unsigned   TW      = $clog2(WIN_CYCLES);
    localparam logic [NK-1:0] REL_LVL = {NK{~KEY_ACTIVE}};

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GATHER = 2'd1,
        HOLD   = 2'd2
    } state_e;

    logic [NK-1:0]         raw_c;
    logic [NK-1:0]         sync1_q;
    logic [NK-1:0]         sync2_q;
    logic [NK-1:0]         stable_q;
    logic [NK-1:0]         stable_d;
    logic [NK-1:0][DW-1:0] deb_cnt_q;
    logic [NK-1:0][DW-1:0] deb_cnt_d;
    logic [NK-1:0]         press_c;
    logic [NK-1:0]         pulse_q;

    state_e                state_q;
    state_e                state_d;
    logic [2:0]            tally_q;
    logic [2:0]            tally_d;
    logic [TW-1:0]         timer_q;
    logic [TW-1:0]         timer_d;
    logic [2:0]            count_q;
    logic [2:0]            count_d;
    logic                  mode_press_c;
    logic                  expiry_c;

    // Mode key rides as the top lane so all four keys share one debounce path.
    assign raw_c = {mode_in, key_in};

    // Synchronisers, debounced levels, debounce counters and press pulses.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q   <= REL_LVL;
            sync2_q   <= REL_LVL;
            stable_q  <= REL_LVL;
            deb_cnt_q <= '0;
            pulse_q   <= '0;
        end else begin
            sync1_q   <= raw_c;
            sync2_q   <= sync1_q;
            stable_q  <= stable_d;
            deb_cnt_q <= deb_cnt_d;
            pulse_q   <= press_c;
        end
    end

    // A level must differ from the stable one for DEB_CYCLES edges in a row to be taken.
    always_comb begin
        stable_d  = stable_q;
        deb_cnt_d = '0;
        press_c   = '0;
        for (int i = 0; i < NK; i++) begin
            if (sync2_q[i] != stable_q[i]) begin
                if (deb_cnt_q[i] == DW'(DEB_CYCLES - 1)) begin
                    stable_d[i] = sync2_q[i];
                    press_c[i]  = (sync2_q[i] == KEY_ACTIVE);
                end else begin
                    deb_cnt_d[i] = deb_cnt_q[i] + DW'(1);
                end
            end
        end
    end

    assign mode_press_c = press_c[NK-1];
    assign expiry_c     = (timer_q == TW'(WIN_CYCLES - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // A press in the expiry cycle keeps the burst open.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (mode_press_c) state_d = GATHER;
            GATHER:  if (!mode_press_c && expiry_c) state_d = HOLD;
            HOLD:    if (clr) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        tally_d = tally_q;
        timer_d = timer_q;
        count_d = count_q;
        case (state_q)
            IDLE: begin
                if (mode_press_c) begin
                    tally_d = 3'd1;
                    timer_d = '0;
                end
            end
            GATHER: begin
                if (mode_press_c) begin
                    tally_d = (tally_q == 3'd7) ? 3'd7 : tally_q + 3'd1;
                    timer_d = '0;
                end else if (expiry_c) begin
                    count_d = tally_q;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            HOLD: begin
                if (clr) begin
                    count_d = '0;
                    tally_d = '0;
                end
            end
            default: begin
                tally_d = '0;
                timer_d = '0;
                count_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tally_q <= '0;
            timer_q <= '0;
            count_q <= '0;
        end else begin
            tally_q <= tally_d;
            timer_q <= timer_d;
            count_q <= count_d;
        end
    end

    assign key_led  = pulse_q[NK-2:0];
    assign key_mode = pulse_q[NK-1];
    assign count    = count_q;

endmodule

// File: tb/tb_key_scan.sv
// Bench for key_scan: directed scenarios plus random key/clr traffic, all checked
// cycle by cycle against a window-based behavioural model of debounce and bursts.
module tb_key_scan;

    localparam int unsigned DEB = 4;
    localparam int unsigned WIN = 16;
    localparam logic [3:0]  REL = 4'b1111;

    logic       clk;
    logic       rst;
    logic [2:0] key_in;
    logic       mode_in;
    logic       clr;
    logic [2:0] key_led;
    logic       key_mode;
    logic [2:0] count;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model state.
    logic [3:0] hist[$];
    int         lastchg[4];
    logic [3:0] m_stable;
    logic [2:0] exp_led;
    logic       exp_mode;
    logic [2:0] exp_count;
    int         cyc;
    int         m_last;
    int         m_tally;
    bit         m_open;
    bit         m_hold;

    key_scan #(
        .DEB_CYCLES(DEB),
        .WIN_CYCLES(WIN),
        .KEY_ACTIVE(1'b0)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .key_in  (key_in),
        .mode_in (mode_in),
        .clr     (clr),
        .key_led (key_led),
        .key_mode(key_mode),
        .count   (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        hist.delete();
        hist.push_back(REL);
        hist.push_back(REL);
        for (int i = 0; i < 4; i++) lastchg[i] = -1;
        m_stable  = REL;
        exp_led   = 3'b000;
        exp_mode  = 1'b0;
        exp_count = 3'd0;
        cyc       = 0;
        m_last    = 0;
        m_tally   = 0;
        m_open    = 1'b0;
        m_hold    = 1'b0;
    endtask

    // A key's level is accepted once its last DEB samples (seen two clocks late)
    // all disagree with the accepted level and none predate the previous acceptance.
    // A burst closes WIN edges after its last press; HOLD drops presses until clr.
    task automatic model_edge();
        logic [3:0] press;
        int         j;
        bit         ok;
        cyc++;
        hist.push_back({mode_in, key_in});
        j     = hist.size() - 3;
        press = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            if (j - int'(DEB) + 1 > lastchg[i]) begin
                ok = 1'b1;
                for (int m = 0; m < int'(DEB); m++) begin
                    if (hist[j-m][i] == m_stable[i]) ok = 1'b0;
                end
                if (ok) begin
                    m_stable[i] = ~m_stable[i];
                    lastchg[i]  = j;
                    press[i]    = (m_stable[i] == 1'b0);
                end
            end
        end
        exp_led  = press[2:0];
        exp_mode = press[3];
        if (m_hold) begin
            if (clr) begin
                exp_count = 3'd0;
                m_tally   = 0;
                m_hold    = 1'b0;
            end
        end else if (m_open) begin
            if (press[3]) begin
                m_tally = (m_tally < 7) ? m_tally + 1 : 7;
                m_last  = cyc;
            end else if (cyc - m_last == int'(WIN)) begin
                exp_count = 3'(m_tally);
                m_hold    = 1'b1;
                m_open    = 1'b0;
            end
        end else if (press[3]) begin
            m_open  = 1'b1;
            m_tally = 1;
            m_last  = cyc;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic test_reset();
        #2 rst = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({key_led, key_mode, count} !== 7'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b, want 0000000", {key_led, key_mode, count});
        end
        rst = 1'b1;
        model_reset();
        for (int t = 0; t < 8; t++) begin
            tick();
            n_cmp++;
            if ({key_led, key_mode, count} !== {exp_led, exp_mode, exp_count}) begin
                n_fail++;
                $display("FAIL reset_idle cyc=%0d: got led=%b mode=%b count=%0d, want led=%b mode=%b count=%0d",
                         cyc, key_led, key_mode, count, exp_led, exp_mode, exp_count);
            end
        end
    endtask

    task automatic test_led_clean();
        int seen  = -1;
        int extra = 0;
        key_in[1] = 1'b0;
        for (int t = 1; t <= 12; t++) begin
            tick();
            n_cmp++;
            if ({key_led, key_mode, count} !== {exp_led, exp_mode, exp_count}) begin
                n_fail++;
                $display("FAIL led_clean cyc=%0d: got led=%b mode=%b count=%0d, want led=%b mode=%b count=%0d",
                         cyc, key_led, key_mode, count, exp_led, exp_mode, exp_count);
            end
            if (key_led === 3'b010 && seen < 0) seen = t;
        end
        n_cmp++;
        if (seen !== 6) begin
            n_fail++;
            $display("FAIL led_latency: got pulse at clock %0d, want 6", seen);
        end
        key_in[1] = 1'b1;
        for (int t = 0; t < 12; t++) begin
            tick();
            if (key_led !== 3'b000) extra++;
        end
        n_cmp++;
        if (extra !== 0) begin
            n_fail++;
            $display("FAIL led_release: got %0d pulses on release, want 0", extra);
        end
    endtask

    task automatic test_bounce();
        int seen  = -1;
        int early = 0;
        int len;
        for (int s = 0; s < 16; s++) begin
            key_in[0] = s[0];
            len = (s < 10) ? 2 : int'($urandom_range(1, 3));
            for (int t = 0; t < len; t++) begin
                tick();
                n_cmp++;
                if ({key_led, key_mode, count} !== {exp_led, exp_mode, exp_count}) begin
                    n_fail++;
                    $display("FAIL bounce cyc=%0d: got led=%b mode=%b count=%0d, want led=%b mode=%b count=%0d",
                             cyc, key_led, key_mode, count, exp_led, exp_mode, exp_count);
                end
                if (key_led !== 3'b000) early++;
            end
        end
        key_in[0] = 1'b0;
        for (int t = 1; t <= 10; t++) begin
            tick();
            if (key_led === 3'b001 && seen < 0) seen = t;
        end
        n_cmp++;
        if (early !== 0) begin
            n_fail++;
            $display("FAIL bounce_quiet: got %0d pulses while bouncing, want 0", early);
        end
        n_cmp++;
        if (seen !== 6) begin
            n_fail++;
            $display("FAIL bounce_latency: got pulse at clock %0d, want 6", seen);
        end
        key_in[0] = 1'b1;
        repeat (10) tick();
    endtask

    task automatic test_two_clicks();
        int p1 = -1;
        int p2 = -1;
        int c2 = -1;
        for (int t = 0; t < 45; t++) begin
            mode_in = ((t < 5) || (t >= 10 && t < 15)) ? 1'b0 : 1'b1;
            tick();
            n_cmp++;
            if ({key_led, key_mode, count} !== {exp_led, exp_mode, exp_count}) begin
                n_fail++;
                $display("FAIL two_clicks cyc=%0d: got led=%b mode=%b count=%0d, want led=%b mode=%b count=%0d",
                         cyc, key_led, key_mode, count, exp_led, exp_mode, exp_count);
            end
            if (key_mode === 1'b1) begin
                if (p1 < 0) p1 = t;
                else p2 = t;
            end
            if (count === 3'd2 && c2 < 0) c2 = t;
        end
        n_cmp++;
        if (p2 - p1 !== 10) begin
            n_fail++;
            $display("FAIL two_clicks_gap: got %0d clocks between pulses, want 10", p2 - p1);
        end
        n_cmp++;
        if (c2 < 0 || c2 - p2 !== 16) begin
            n_fail++;
            $display("FAIL two_clicks_window: got count=2 at %0d clocks after pulse, want 16", c2 - p2);
        end
        n_cmp++;
        if (count !== 3'd2) begin
            n_fail++;
            $display("FAIL two_clicks_hold: got count=%0d, want 2", count);
        end
        clr = 1'b1;
        tick();
        clr = 1'b0;
        n_cmp++;
        if (count !== 3'd0) begin
            n_fail++;
            $display("FAIL two_clicks_clr: got count=%0d, want 0", count);
        end
    endtask

    task automatic test_saturate();
        int pulses = 0;
        int gap;
        for (int k = 0; k < 9; k++) begin
            gap = int'($urandom_range(5, 7));
            for (int t = 0; t < 5 + gap; t++) begin
                mode_in = (t < 5) ? 1'b0 : 1'b1;
                tick();
                n_cmp++;
                if ({key_led, key_mode, count} !== {exp_led, exp_mode, exp_count}) begin
                    n_fail++;
                    $display("FAIL saturate cyc=%0d: got led=%b mode=%b count=%0d, want led=%b mode=%b count=%0d",
                             cyc, key_led, key_mode, count, exp_led, exp_mode, exp_count);
                end
                if (key_mode === 1'b1) pulses++;
            end
        end
        repeat (30) tick();
        n_cmp++;
        if (pulses !== 9) begin
            n_fail++;
            $display("FAIL saturate_pulses: got %0d key_mode pulses, want 9", pulses);
        end
        n_cmp++;
        if (count !== 3'd7) begin
            n_fail++;
            $display("FAIL saturate_count: got count=%0d, want 7", count);
        end
        clr = 1'b1;
        tick();
        clr = 1'b0;
        tick();
    endtask

    task automatic test_expiry_press();
        int p[3] = '{-1, -1, -1};
        int np   = 0;
        int c    = -1;
        for (int t = 0; t < 62; t++) begin
            mode_in = ((t < 5) || (t >= 16 && t < 21) || (t >= 46 && t < 51)) ? 1'b0 : 1'b1;
            tick();
            n_cmp++;
            if ({key_led, key_mode, count} !== {exp_led, exp_mode, exp_count}) begin
                n_fail++;
                $display("FAIL expiry cyc=%0d: got led=%b mode=%b count=%0d, want led=%b mode=%b count=%0d",
                         cyc, key_led, key_mode, count, exp_led, exp_mode, exp_count);
            end
            if (key_mode === 1'b1) begin
                if (np < 3) p[np] = t;
                np++;
            end
            if (count !== 3'd0 && c < 0) c = t;
        end
        n_cmp++;
        if (p[1] - p[0] !== 16) begin
            n_fail++;
            $display("FAIL expiry_gap: got %0d clocks between pulses, want 16", p[1] - p[0]);
        end
        n_cmp++;
        if (c < 0 || c - p[1] !== 16) begin
            n_fail++;
            $display("FAIL expiry_extend: got count at %0d clocks after 2nd pulse, want 16", c - p[1]);
        end
        n_cmp++;
        if (np !== 3) begin
            n_fail++;
            $display("FAIL hold_pulse: got %0d key_mode pulses, want 3", np);
        end
        n_cmp++;
        if (count !== 3'd2) begin
            n_fail++;
            $display("FAIL hold_drop: got count=%0d, want 2", count);
        end
        clr = 1'b1;
        tick();
        clr = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid();
        int pulses = 0;
        int led_at = -1;
        for (int t = 0; t < 29; t++) begin
            mode_in = ((t % 10) < 5) ? 1'b0 : 1'b1;
            tick();
            if (key_mode === 1'b1) pulses++;
        end
        n_cmp++;
        if (pulses !== 3 || count !== 3'd0) begin
            n_fail++;
            $display("FAIL pre_reset: got %0d pulses count=%0d, want 3 pulses count=0", pulses, count);
        end
        key_in[2] = 1'b0;
        rst       = 1'b0;
        #1;
        n_cmp++;
        if ({key_led, key_mode, count} !== 7'd0) begin
            n_fail++;
            $display("FAIL reset_async: got %b, want 0000000", {key_led, key_mode, count});
        end
        for (int t = 0; t < 3; t++) begin
            @(negedge clk);
            n_cmp++;
            if ({key_led, key_mode, count} !== 7'd0) begin
                n_fail++;
                $display("FAIL reset_held: got %b, want 0000000", {key_led, key_mode, count});
            end
        end
        rst = 1'b1;
        model_reset();
        for (int t = 0; t < 45; t++) begin
            mode_in = (t >= 10 && t < 15) ? 1'b0 : 1'b1;
            tick();
            n_cmp++;
            if ({key_led, key_mode, count} !== {exp_led, exp_mode, exp_count}) begin
                n_fail++;
                $display("FAIL post_reset cyc=%0d: got led=%b mode=%b count=%0d, want led=%b mode=%b count=%0d",
                         cyc, key_led, key_mode, count, exp_led, exp_mode, exp_count);
            end
            if (key_led === 3'b100 && led_at < 0) led_at = t + 1;
        end
        n_cmp++;
        if (led_at !== 6) begin
            n_fail++;
            $display("FAIL held_through_reset: got pulse at clock %0d, want 6", led_at);
        end
        n_cmp++;
        if (count !== 3'd1) begin
            n_fail++;
            $display("FAIL post_reset_count: got count=%0d, want 1", count);
        end
        clr       = 1'b1;
        tick();
        clr       = 1'b0;
        key_in[2] = 1'b1;
        repeat (10) tick();
    endtask

    task automatic test_random();
        int         hold[4];
        logic [3:0] lvl;
        lvl = REL;
        for (int i = 0; i < 4; i++) hold[i] = 0;
        for (int t = 0; t < 800; t++) begin
            for (int i = 0; i < 4; i++) begin
                if (hold[i] == 0) begin
                    lvl[i]  = ~lvl[i];
                    hold[i] = ($urandom_range(0, 2) == 0) ? int'($urandom_range(4, 20))
                                                          : int'($urandom_range(1, 3));
                end
                hold[i]--;
            end
            key_in  = lvl[2:0];
            mode_in = lvl[3];
            clr     = ($urandom_range(0, 7) == 0);
            tick();
            n_cmp++;
            if ({key_led, key_mode, count} !== {exp_led, exp_mode, exp_count}) begin
                n_fail++;
                $display("FAIL random cyc=%0d: got led=%b mode=%b count=%0d, want led=%b mode=%b count=%0d",
                         cyc, key_led, key_mode, count, exp_led, exp_mode, exp_count);
            end
        end
        clr     = 1'b0;
        key_in  = 3'b111;
        mode_in = 1'b1;
        for (int t = 0; t < 40; t++) begin
            tick();
            n_cmp++;
            if ({key_led, key_mode, count} !== {exp_led, exp_mode, exp_count}) begin
                n_fail++;
                $display("FAIL random_settle cyc=%0d: got led=%b mode=%b count=%0d, want led=%b mode=%b count=%0d",
                         cyc, key_led, key_mode, count, exp_led, exp_mode, exp_count);
            end
        end
    endtask

    initial begin
        rst     = 1'b1;
        key_in  = 3'b111;
        mode_in = 1'b1;
        clr     = 1'b0;
        model_reset();
        test_reset();
        test_led_clean();
        test_bounce();
        test_two_clicks();
        test_saturate();
        test_expiry_press();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
